// File: rtl/cpu_pkg.sv
// Shared definitions for the control sequencer: the state encoding, the
// 5-bit opcode constants, the ALU idle opcode, and helpers that classify
// an opcode.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH0 = 3'd0,
    S_FETCH1 = 3'd1,
    S_FETCH2 = 3'd2,
    S_EX3    = 3'd3,
    S_EX4    = 3'd4,
    S_EX5    = 3'd5,
    S_EX6    = 3'd6,
    S_HALT   = 3'd7
  } state_e;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_NOP = 5'b11111;

  // Three-register ALU operations whose result fits in Z low.
  function automatic logic is_rtype(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL: is_rtype = 1'b1;
      default:                         is_rtype = 1'b0;
    endcase
  endfunction

  // Operations producing a 64-bit result split across LO and HI.
  function automatic logic is_muldiv(input logic [4:0] op);
    is_muldiv = (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Register-field decoder: turns a 4-bit register number into a 16-bit
// one-hot enable vector, or all zeros when not enabled.
//   sel    in  4   register number (bit n of onehot = Rn)
//   en     in  1   1 = drive the selected bit
//   onehot out 16  one-hot enables
module reg_select_decoder (
  input  logic [3:0]  sel,
  input  logic        en,
  output logic [15:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Control sequencer for a simple register-file datapath. Steps each
// instruction through fetch and up to four execute cycles, driving the
// datapath strobes from the registered state and the instruction register.
//   clock      in   1   system clock, rising edge
//   clear      in   1   synchronous active-low reset
//   run        in   1   permits a new fetch from FETCH0
//   mem_ready  in   1   memory read data valid this cycle
//   ir         in   32  instruction: op[31:27] Ra[26:23] Rb[22:19] Rc[18:15]
//   Rout/Rin   out  16  one-hot register drive / load enables
//   PCout..LOin out 1   datapath strobes
//   opcode     out  5   ALU operation (ALU_NOP except in EX4)
//   done       out  1   last cycle of an instruction
//   illegal    out  1   undefined opcode decoded
//   halted     out  1   level, in HALT
//
// state   | meaning
// FETCH0  | idle / PC to MAR, start PC increment
// FETCH1  | memory read, waits for mem_ready, loads PC+1
// FETCH2  | MDR to IR
// EX3     | decode; Rb into Y, or finish NOP/HALT/illegal
// EX4     | Rc to ALU, result into Z
// EX5     | Z low to Ra (R-type) or to LO (MUL/DIV)
// EX6     | Z high to HI (MUL/DIV)
// HALT    | stopped until reset
module control_sequencer
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic [4:0]  opcode,
  output logic        done,
  output logic        illegal,
  output logic        halted
);

  state_e state_q, state_d;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic [3:0] rout_sel;
  logic       rout_en, rin_en;
  logic       unused_ir;

  assign op = ir[31:27];
  assign ra = ir[26:23];
  assign rb = ir[22:19];
  assign rc = ir[18:15];
  assign unused_ir = ^ir[14:0];

  always_ff @(posedge clock) begin
    if (!clear) state_q <= S_FETCH0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    PCout    = 1'b0;
    PCin     = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    opcode   = ALU_NOP;
    done     = 1'b0;
    illegal  = 1'b0;
    halted   = 1'b0;
    rout_en  = 1'b0;
    rout_sel = rb;
    rin_en   = 1'b0;

    case (state_q)
      S_FETCH0: begin
        if (run) begin
          PCout   = 1'b1;
          MARin   = 1'b1;
          IncPC   = 1'b1;
          Zin     = 1'b1;
          state_d = S_FETCH1;
        end
      end
      S_FETCH1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        if (mem_ready) begin
          Zlowout = 1'b1;
          PCin    = 1'b1;
          state_d = S_FETCH2;
        end
      end
      S_FETCH2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = S_EX3;
      end
      S_EX3: begin
        if (is_rtype(op) || is_muldiv(op)) begin
          rout_en  = 1'b1;
          rout_sel = rb;
          Yin      = 1'b1;
          state_d  = S_EX4;
        end else if (op == OP_NOP) begin
          done    = 1'b1;
          state_d = S_FETCH0;
        end else if (op == OP_HALT) begin
          done    = 1'b1;
          state_d = S_HALT;
        end else begin
          illegal = 1'b1;
          done    = 1'b1;
          state_d = S_FETCH0;
        end
      end
      S_EX4: begin
        rout_en  = 1'b1;
        rout_sel = rc;
        Zin      = 1'b1;
        opcode   = op;
        state_d  = S_EX5;
      end
      S_EX5: begin
        Zlowout = 1'b1;
        if (is_muldiv(op)) begin
          LOin    = 1'b1;
          state_d = S_EX6;
        end else begin
          rin_en  = 1'b1;
          done    = 1'b1;
          state_d = S_FETCH0;
        end
      end
      S_EX6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        done     = 1'b1;
        state_d  = S_FETCH0;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_FETCH0;
    endcase
  end

  reg_select_decoder u_rout_dec (
    .sel    (rout_sel),
    .en     (rout_en),
    .onehot (Rout)
  );

  reg_select_decoder u_rin_dec (
    .sel    (ra),
    .en     (rin_en),
    .onehot (Rin)
  );

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        run = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] ir = '0;
  logic [15:0] Rout, Rin;
  logic PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
  logic Yin, Zin, Zlowout, Zhighout, HIin, LOin;
  logic [4:0]  opcode;
  logic done, illegal, halted;

  control_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
    .Rout(Rout), .Rin(Rin),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
    .opcode(opcode), .done(done), .illegal(illegal), .halted(halted)
  );

  always #5 clock = ~clock;

  localparam logic [13:0] B_PCOUT = 14'h2000, B_PCIN  = 14'h1000,
                          B_INCPC = 14'h0800, B_MARIN = 14'h0400,
                          B_READ  = 14'h0200, B_MDRIN = 14'h0100,
                          B_MDROUT= 14'h0080, B_IRIN  = 14'h0040,
                          B_YIN   = 14'h0020, B_ZIN   = 14'h0010,
                          B_ZLO   = 14'h0008, B_ZHI   = 14'h0004,
                          B_HIIN  = 14'h0002, B_LOIN  = 14'h0001;
  localparam logic [4:0] NOPC = 5'b11111;

  logic [53:0] obs;
  assign obs = {Rout, Rin, PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
                Yin, Zin, Zlowout, Zhighout, HIin, LOin, opcode, done, illegal, halted};

  logic [53:0] exp_q[$];
  string       tag_q[$];
  int n_cmp = 0;
  int n_mis = 0;

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'h5A5A};
  endfunction

  function automatic logic [53:0] ev(input logic [15:0] ro, input logic [15:0] ri,
                                     input logic [13:0] st, input logic [4:0] opc,
                                     input logic d, input logic il, input logic h);
    return {ro, ri, st, opc, d, il, h};
  endfunction

  task automatic cyc(input string tag, input logic [53:0] e);
    logic [53:0] x;
    string t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clock);
    x = exp_q.pop_front();
    t = tag_q.pop_front();
    n_cmp++;
    assert (obs === x) else begin
      n_mis++;
      $error("FAIL %s: observed=%h expected=%h", t, obs, x);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_fetch(input string nm, input logic [31:0] instr);
    ir = instr;
    run = 1'b1;
    mem_ready = 1'b1;
    cyc({nm, ".f0"}, ev(16'h0, 16'h0, B_PCOUT | B_MARIN | B_INCPC | B_ZIN, NOPC, 0, 0, 0));
    cyc({nm, ".f1"}, ev(16'h0, 16'h0, B_READ | B_MDRIN | B_ZLO | B_PCIN, NOPC, 0, 0, 0));
    cyc({nm, ".f2"}, ev(16'h0, 16'h0, B_MDROUT | B_IRIN, NOPC, 0, 0, 0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    @(posedge clock);
    #1;
    cyc("reset", ev(16'h0, 16'h0, 14'h0, NOPC, 0, 0, 0));
    clear = 1'b1;
    cyc("idle", ev(16'h0, 16'h0, 14'h0, NOPC, 0, 0, 0));

    // AND R4,R5,R6; run dropped mid-instruction must not matter
    do_fetch("and", mk_ir(5'b00101, 4'd4, 4'd5, 4'd6));
    run = 1'b0;
    cyc("and.ex3", ev(16'h0020, 16'h0, B_YIN, NOPC, 0, 0, 0));
    cyc("and.ex4", ev(16'h0040, 16'h0, B_ZIN, 5'b00101, 0, 0, 0));
    cyc("and.ex5", ev(16'h0, 16'h0010, B_ZLO, NOPC, 1, 0, 0));
    cyc("and.idle", ev(16'h0, 16'h0, 14'h0, NOPC, 0, 0, 0));

    // MUL R1,R2,R3
    do_fetch("mul", mk_ir(5'b01111, 4'd1, 4'd2, 4'd3));
    cyc("mul.ex3", ev(16'h0004, 16'h0, B_YIN, NOPC, 0, 0, 0));
    cyc("mul.ex4", ev(16'h0008, 16'h0, B_ZIN, 5'b01111, 0, 0, 0));
    cyc("mul.ex5", ev(16'h0, 16'h0, B_ZLO | B_LOIN, NOPC, 0, 0, 0));
    cyc("mul.ex6", ev(16'h0, 16'h0, B_ZHI | B_HIIN, NOPC, 1, 0, 0));

    // DIV R15,R14,R13 starts immediately (run still 1)
    do_fetch("div", mk_ir(5'b10000, 4'd15, 4'd14, 4'd13));
    cyc("div.ex3", ev(16'h4000, 16'h0, B_YIN, NOPC, 0, 0, 0));
    cyc("div.ex4", ev(16'h2000, 16'h0, B_ZIN, 5'b10000, 0, 0, 0));
    cyc("div.ex5", ev(16'h0, 16'h0, B_ZLO | B_LOIN, NOPC, 0, 0, 0));
    cyc("div.ex6", ev(16'h0, 16'h0, B_ZHI | B_HIIN, NOPC, 1, 0, 0));

    // ADD R0,R0,R0 with three memory wait states
    ir = mk_ir(5'b00011, 4'd0, 4'd0, 4'd0);
    run = 1'b1;
    mem_ready = 1'b0;
    cyc("ws.f0", ev(16'h0, 16'h0, B_PCOUT | B_MARIN | B_INCPC | B_ZIN, NOPC, 0, 0, 0));
    run = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc($sformatf("ws.wait%0d", i), ev(16'h0, 16'h0, B_READ | B_MDRIN, NOPC, 0, 0, 0));
    mem_ready = 1'b1;
    cyc("ws.f1rdy", ev(16'h0, 16'h0, B_READ | B_MDRIN | B_ZLO | B_PCIN, NOPC, 0, 0, 0));
    mem_ready = 1'b0;
    cyc("ws.f2", ev(16'h0, 16'h0, B_MDROUT | B_IRIN, NOPC, 0, 0, 0));
    cyc("ws.ex3", ev(16'h0001, 16'h0, B_YIN, NOPC, 0, 0, 0));
    cyc("ws.ex4", ev(16'h0001, 16'h0, B_ZIN, 5'b00011, 0, 0, 0));
    cyc("ws.ex5", ev(16'h0, 16'h0001, B_ZLO, NOPC, 1, 0, 0));
    cyc("ws.idle", ev(16'h0, 16'h0, 14'h0, NOPC, 0, 0, 0));

    // undefined opcode
    do_fetch("ill", mk_ir(5'b11100, 4'd7, 4'd8, 4'd9));
    run = 1'b0;
    cyc("ill.ex3", ev(16'h0, 16'h0, 14'h0, NOPC, 1, 1, 0));
    cyc("ill.idle", ev(16'h0, 16'h0, 14'h0, NOPC, 0, 0, 0));

    // NOP
    do_fetch("nop", mk_ir(5'b11010, 4'd2, 4'd3, 4'd4));
    run = 1'b0;
    cyc("nop.ex3", ev(16'h0, 16'h0, 14'h0, NOPC, 1, 0, 0));
    cyc("nop.idle", ev(16'h0, 16'h0, 14'h0, NOPC, 0, 0, 0));

    // abort SUB R9,R10,R11 during EX4
    do_fetch("abt", mk_ir(5'b00100, 4'd9, 4'd10, 4'd11));
    cyc("abt.ex3", ev(16'h0400, 16'h0, B_YIN, NOPC, 0, 0, 0));
    clear = 1'b0;
    run = 1'b0;
    cyc("abt.ex4", ev(16'h0800, 16'h0, B_ZIN, 5'b00100, 0, 0, 0));
    clear = 1'b1;
    cyc("abt.rst", ev(16'h0, 16'h0, 14'h0, NOPC, 0, 0, 0));
    cyc("abt.idle", ev(16'h0, 16'h0, 14'h0, NOPC, 0, 0, 0));

    // HALT, ignore run, leave via reset
    do_fetch("hlt", mk_ir(5'b11011, 4'd0, 4'd0, 4'd0));
    cyc("hlt.ex3", ev(16'h0, 16'h0, 14'h0, NOPC, 1, 0, 0));
    for (int i = 0; i < 5; i++)
      cyc($sformatf("hlt.run%0d", i), ev(16'h0, 16'h0, 14'h0, NOPC, 0, 0, 1));
    clear = 1'b0;
    run = 1'b0;
    cyc("hlt.clr", ev(16'h0, 16'h0, 14'h0, NOPC, 0, 0, 1));
    clear = 1'b1;
    cyc("hlt.out", ev(16'h0, 16'h0, 14'h0, NOPC, 0, 0, 0));
    run = 1'b1;
    cyc("hlt.refetch", ev(16'h0, 16'h0, B_PCOUT | B_MARIN | B_INCPC | B_ZIN, NOPC, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
